// File: rtl/conv_out_pkg.sv
// ============================================================================
//  Module   : conv_out_pkg
//  Brief    : Shared types and address helper for the conv output collector.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package conv_out_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      DRAIN   = 2'd2,
      DONE    = 2'd3
   } state_t;

   // Fields are sized for the widest supported configuration; the top uses the low bits.
   localparam int c_ENTRY_FIELD_W = 32;

   typedef struct packed {
      logic [c_ENTRY_FIELD_W-1:0] data;
      logic [c_ENTRY_FIELD_W-1:0] addr;
   } out_entry_t;

   function automatic logic [c_ENTRY_FIELD_W-1:0] calc_addr(
      input int unsigned x,
      input int unsigned y,
      input int unsigned ch,
      input int unsigned w,
      input int unsigned h
   );
      return c_ENTRY_FIELD_W'(ch * (w * h) + y * w + x);
   endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
//  Module   : sync_fifo
//  Brief    : Single-clock FIFO with type parameter; push while full allowed with pop.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sync_fifo #(
   parameter type T     = logic [7:0],
   parameter int  DEPTH = 8
) (
   input  logic clk,
   input  logic arst,
   input  logic push,
   input  T     din,
   input  logic pop,
   output T     dout,
   output logic full,
   output logic empty
);

   localparam int c_PTR_W = $clog2(DEPTH);

   T                 r_mem [DEPTH];
   logic [c_PTR_W:0] r_wr_ptr;
   logic [c_PTR_W:0] r_rd_ptr;
   logic             w_do_push;
   logic             w_do_pop;

   assign w_do_pop  = pop && !empty;
   assign w_do_push = push && (!full || w_do_pop);

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Storage needs no reset: the read side is qualified by empty.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[c_PTR_W-1:0]] <= din;
   end

   assign empty = (r_wr_ptr == r_rd_ptr);
   assign full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                  (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
   assign dout  = r_mem[r_rd_ptr[c_PTR_W-1:0]];

endmodule

`default_nettype wire

// File: rtl/conv_output_collector.sv
// ============================================================================
//  Module   : conv_output_collector
//  Brief    : Collects conv core results, optional ReLU (macro OUT_RELU_EN),
//             linear addressing, FIFO buffering and per-layer completion.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module conv_output_collector
   import conv_out_pkg::*;
#(
   parameter int DATA_WIDTH         = 16,
   parameter int FEATURE_MAP_WIDTH  = 128,
   parameter int FEATURE_MAP_HEIGHT = 128,
   parameter int OUTPUT_NB_CHANNELS = 32,
   parameter int FIFO_DEPTH         = 8,
   localparam int ADDR_W = $clog2(FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS),
   localparam int CNT_W  = $clog2(FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS + 1),
   localparam int X_W    = $clog2(FEATURE_MAP_WIDTH),
   localparam int Y_W    = $clog2(FEATURE_MAP_HEIGHT),
   localparam int CH_W   = $clog2(OUTPUT_NB_CHANNELS)
) (
   input  logic                         clk,
   input  logic                         arst,
   input  logic                         start,
   input  logic signed [DATA_WIDTH-1:0] in_data,
   input  logic                         in_valid,
   input  logic [X_W-1:0]               in_x,
   input  logic [Y_W-1:0]               in_y,
   input  logic [CH_W-1:0]              in_ch,
   output logic [DATA_WIDTH-1:0]        out_data,
   output logic [ADDR_W-1:0]            out_addr,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic                         done,
   output logic                         overflow,
   output logic [CNT_W-1:0]             count
);

   localparam int c_TOTAL = FEATURE_MAP_WIDTH * FEATURE_MAP_HEIGHT * OUTPUT_NB_CHANNELS;

   state_t                  r_state;
   state_t                  w_state_nxt;
   logic [CNT_W-1:0]        r_count;
   logic                    r_overflow;
   logic                    w_arm;
   logic                    w_push_req;
   logic                    w_pop;
   logic                    w_full;
   logic                    w_empty;
   logic [DATA_WIDTH-1:0]   w_data_in;
   out_entry_t              w_entry_in;
   out_entry_t              w_entry_out;
   logic                    w_unused;

   // ------------------------------------------------------------------
   // Layer FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge arst) begin
      if (arst) r_state <= IDLE;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (start) w_state_nxt = COLLECT;
         COLLECT: if (r_count == CNT_W'(c_TOTAL)) w_state_nxt = DRAIN;
         DRAIN:   if (w_empty) w_state_nxt = DONE;
         DONE:    if (start) w_state_nxt = COLLECT;
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_arm      = start && ((r_state == IDLE) || (r_state == DONE));
   assign w_push_req = in_valid && (r_state == COLLECT);
   assign w_pop      = out_valid && out_ready;

   // ------------------------------------------------------------------
   // Per-layer result counter and sticky drop flag
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (w_arm) begin
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else if (w_push_req) begin
         r_count <= r_count + 1'b1;
         if (w_full && !w_pop) r_overflow <= 1'b1;
      end
   end

   // ------------------------------------------------------------------
   // Data conditioning and address generation
   // ------------------------------------------------------------------
`ifdef OUT_RELU_EN
   assign w_data_in = in_data[DATA_WIDTH-1] ? '0 : in_data;
`else
   assign w_data_in = in_data;
`endif

   always_comb begin
      w_entry_in                      = '0;
      w_entry_in.data[DATA_WIDTH-1:0] = w_data_in;
      w_entry_in.addr = calc_addr(32'(in_x), 32'(in_y), 32'(in_ch),
                                  32'(FEATURE_MAP_WIDTH), 32'(FEATURE_MAP_HEIGHT));
   end

   // The FIFO rejects a push when full unless a pop frees a slot the same cycle.
   sync_fifo #(
      .T     (out_entry_t),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .arst  (arst),
      .push  (w_push_req),
      .din   (w_entry_in),
      .pop   (w_pop),
      .dout  (w_entry_out),
      .full  (w_full),
      .empty (w_empty)
   );

   // ------------------------------------------------------------------
   // Outputs; data/addr forced to zero while nothing is buffered
   // ------------------------------------------------------------------
   assign out_valid = !w_empty;
   assign out_data  = w_empty ? '0 : w_entry_out.data[DATA_WIDTH-1:0];
   assign out_addr  = w_empty ? '0 : w_entry_out.addr[ADDR_W-1:0];
   assign done      = (r_state == DONE);
   assign overflow  = r_overflow;
   assign count     = r_count;

   assign w_unused = ^(w_entry_out.data >> DATA_WIDTH) ^ ^(w_entry_out.addr >> ADDR_W);

endmodule

`default_nettype wire

// File: tb/tb_conv_output_collector.sv
// ============================================================================
//  Module   : tb_conv_output_collector
//  Brief    : Scoreboard bench for conv_output_collector (W=4,H=4,C=2,depth 4).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_conv_output_collector;

   localparam int W     = 4;
   localparam int H     = 4;
   localparam int C     = 2;
   localparam int D     = 4;
   localparam int DW    = 16;
   localparam int TOTAL = W * H * C;

   logic                 clk = 1'b0;
   logic                 arst;
   logic                 start;
   logic signed [DW-1:0] in_data;
   logic                 in_valid;
   logic [1:0]           in_x;
   logic [1:0]           in_y;
   logic [0:0]           in_ch;
   logic [DW-1:0]        out_data;
   logic [4:0]           out_addr;
   logic                 out_valid;
   logic                 out_ready;
   logic                 done;
   logic                 overflow;
   logic [5:0]           count;

   typedef struct {
      logic [DW-1:0] data;
      logic [4:0]    addr;
   } exp_t;

   exp_t exp_q[$];
   int   occ;
   int   exp_count;
   bit   exp_ovf;
   bit   layer_open;
   int   writes;
   int   vectors;
   int   miscompares;

   conv_output_collector #(
      .DATA_WIDTH         (DW),
      .FEATURE_MAP_WIDTH  (W),
      .FEATURE_MAP_HEIGHT (H),
      .OUTPUT_NB_CHANNELS (C),
      .FIFO_DEPTH         (D)
   ) dut (
      .clk       (clk),
      .arst      (arst),
      .start     (start),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_x      (in_x),
      .in_y      (in_y),
      .in_ch     (in_ch),
      .out_data  (out_data),
      .out_addr  (out_addr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .done      (done),
      .overflow  (overflow),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] ref_data(input int d);
`ifdef OUT_RELU_EN
      return (d < 0) ? '0 : DW'(d);
`else
      return DW'(d);
`endif
   endfunction

   // Monitor: every accepted write is compared with the oldest expected entry.
   always @(negedge clk) begin
      if (!arst && out_valid && out_ready) begin
         writes++;
         if (exp_q.size() == 0) begin
            check("unexpected_write", 32'(out_addr), 32'hFFFF_FFFF);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("wr_data", 32'(out_data), 32'(e.data));
            check("wr_addr", 32'(out_addr), 32'(e.addr));
         end
      end
   end

   // One clock of stimulus; the reference model tracks buffer occupancy arithmetically.
   task automatic step(input bit v, input int x, input int y, input int ch,
                       input int data, input bit rdy, input bit st);
      bit   pop;
      exp_t e;
      start     = st;
      in_valid  = v;
      in_x      = 2'(x);
      in_y      = 2'(y);
      in_ch     = 1'(ch);
      in_data   = DW'(data);
      out_ready = rdy;
      pop = (occ > 0) && rdy;
      if (v && layer_open && exp_count < TOTAL) begin
         exp_count++;
         if (occ < D || pop) begin
            e.data = ref_data(data);
            e.addr = 5'(ch * W * H + y * W + x);
            exp_q.push_back(e);
            occ++;
         end else begin
            exp_ovf = 1'b1;
         end
      end
      if (pop) occ--;
      @(posedge clk);
      #1;
      if (st && !layer_open) begin
         layer_open = 1'b1;
         exp_count  = 0;
         exp_ovf    = 1'b0;
      end
      start    = 1'b0;
      in_valid = 1'b0;
   endtask

   task automatic idle(input bit rdy);
      step(1'b0, 0, 0, 0, 0, rdy, 1'b0);
   endtask

   task automatic do_reset();
      arst       = 1'b1;
      start      = 1'b0;
      in_valid   = 1'b0;
      #2;
      exp_q.delete();
      occ        = 0;
      exp_count  = 0;
      exp_ovf    = 1'b0;
      layer_open = 1'b0;
      @(posedge clk);
      #1;
      arst = 1'b0;
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 60; i++) begin
         if (!out_valid && occ == 0) break;
         idle(1'b1);
      end
      check("drained", 32'(out_valid), 32'd0);
   endtask

   task automatic wait_done();
      for (int i = 0; i < 20; i++) begin
         if (done) break;
         idle(1'b1);
      end
      check("done", 32'(done), 32'd1);
      layer_open = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int w0;
      vectors     = 0;
      miscompares = 0;
      writes      = 0;
      out_ready   = 1'b0;
      in_data     = '0;
      in_x        = '0;
      in_y        = '0;
      in_ch       = '0;
      do_reset();
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_done",  32'(done),      32'd0);
      check("rst_count", 32'(count),     32'd0);
      check("rst_data",  32'(out_data),  32'd0);
      check("rst_addr",  32'(out_addr),  32'd0);

      // Reset mid-layer with three entries queued
      step(1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b1, i, 0, 0, 10 + i, 1'b0, 1'b0);
      check("pre_rst_count", 32'(count), 32'd3);
      arst = 1'b1;
      #1;
      check("arst_valid", 32'(out_valid), 32'd0);
      check("arst_count", 32'(count),     32'd0);
      check("arst_ovf",   32'(overflow),  32'd0);
      do_reset();
      step(1'b1, 1, 1, 0, 99, 1'b1, 1'b0);
      check("idle_ignore_count", 32'(count),     32'd0);
      check("idle_ignore_valid", 32'(out_valid), 32'd0);

      // Address mapping and single-cycle latency
      step(1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
      check("lat_before", 32'(out_valid), 32'd0);
      step(1'b1, 3, 2, 1, 5, 1'b0, 1'b0);
      check("lat_valid", 32'(out_valid), 32'd1);
      check("addr_27",   32'(out_addr),  32'd27);
      check("data_5",    32'(out_data),  32'd5);
      idle(1'b0);
      check("hold_addr", 32'(out_addr), 32'd27);
      do_reset();

      // Full layer, back-to-back with out_ready high
      step(1'b0, 0, 0, 0, 0, 1'b1, 1'b1);
      w0 = writes;
      for (int n = 0; n < TOTAL; n++)
         step(1'b1, n % W, (n / W) % H, n / (W * H), n * 3 - 40, 1'b1, 1'b0);
      check("full_done_early", 32'(done), 32'd0);
      wait_done();
      check("full_writes", 32'(writes - w0), 32'(TOTAL));
      check("full_ovf",    32'(overflow),    32'd0);
      check("full_count",  32'(count),       32'(TOTAL));

      // Push into a full FIFO while it pops in the same cycle
      step(1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
      check("rearm_count", 32'(count), 32'd0);
      check("rearm_done",  32'(done),  32'd0);
      for (int i = 0; i < D; i++) step(1'b1, i, 1, 0, 100 + i, 1'b0, 1'b0);
      step(1'b1, 0, 3, 1, 777, 1'b1, 1'b0);
      check("fullpop_ovf",   32'(overflow), 32'd0);
      check("fullpop_count", 32'(count),    32'(D + 1));
      wait_drain();
      do_reset();

      // Backpressure drops
      step(1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) step(1'b1, i % W, 2, 1, 200 + i, 1'b0, 1'b0);
      check("bp_ovf",   32'(overflow), 32'd1);
      check("bp_count", 32'(count),    32'd6);
      w0 = writes;
      wait_drain();
      check("bp_writes", 32'(writes - w0), 32'd4);
      do_reset();

      // ReLU on a negative value; start while draining is ignored
      step(1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
      step(1'b1, 0, 0, 0, -7, 1'b0, 1'b0);
      for (int n = 1; n < TOTAL; n++)
         step(1'b1, n % W, (n / W) % H, n / (W * H), int'($urandom_range(0, 65535)) - 32768, 1'b0, 1'b0);
      idle(1'b0);
      idle(1'b0);
      step(1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
      idle(1'b0);
      check("drain_start_count", 32'(count),    32'(TOTAL));
      check("drain_start_ovf",   32'(overflow), 32'd1);
      check("drain_done",        32'(done),     32'd0);
      check("relu_head",         32'(out_data), 32'(ref_data(-7)));
      wait_drain();
      wait_done();

      // Randomized layer: gaps, random ready, random coordinates and data
      step(1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
      for (int n = 0; n < TOTAL; n++) begin
         while ($urandom_range(0, 3) == 0) idle(1'($urandom_range(0, 1)));
         step(1'b1, int'($urandom_range(0, W - 1)), int'($urandom_range(0, H - 1)),
              int'($urandom_range(0, C - 1)), int'($urandom_range(0, 65535)) - 32768,
              1'($urandom_range(0, 1)), 1'b0);
      end
      wait_drain();
      wait_done();
      check("rand_ovf",   32'(overflow), 32'(exp_ovf));
      check("rand_count", 32'(count),    32'(TOTAL));
      check("sb_empty",   32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
